sized_fifo_cnt: RTL and testbench

//  Parametrised-depth, single-clock FIFO generalising the fixed depth-2 FIFO.

---
 rtl/sized_fifo_cnt_pkg.sv | 31 +++
 rtl/sized_fifo_cnt_if.sv | 31 +++
 rtl/sized_fifo_cnt_wrap_ctr.sv | 34 +++
 rtl/sized_fifo_cnt.sv | 119 +++++++++++
 tb/tb_sized_fifo_cnt.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sized_fifo_cnt_pkg.sv
// Shared helpers for sized_fifo_cnt: width functions and reset values of the status flags.
package sized_fifo_cnt_pkg;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Pointer width for indices 0..depth-1 (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // Count width for occupancy 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
    endfunction

    localparam logic RST_FULL_N         = 1'b1;
    localparam logic RST_EMPTY_N        = 1'b0;
    localparam logic RST_ALMOST_EMPTY_N = 1'b0;

endpackage

// File: rtl/sized_fifo_cnt_if.sv
// ENQ/DEQ/FULL_N/EMPTY_N/CLR FIFO bus; master is the producer/consumer side, slave is the FIFO.
interface sized_fifo_cnt_if
    import sized_fifo_cnt_pkg::*;
#(
    parameter int unsigned width = 1,
    parameter int unsigned depth = 4
);
    localparam int unsigned CW = cnt_w(depth);

    logic [width-1:0] D_IN;
    logic             ENQ;
    logic             DEQ;
    logic             CLR;
    logic [width-1:0] D_OUT;
    logic             FULL_N;
    logic             EMPTY_N;
    logic             ALMOST_FULL_N;
    logic             ALMOST_EMPTY_N;
    logic [CW-1:0]    COUNT;

    modport master (
        output D_IN, ENQ, DEQ, CLR,
        input  D_OUT, FULL_N, EMPTY_N, ALMOST_FULL_N, ALMOST_EMPTY_N, COUNT
    );

    modport slave (
        input  D_IN, ENQ, DEQ, CLR,
        output D_OUT, FULL_N, EMPTY_N, ALMOST_FULL_N, ALMOST_EMPTY_N, COUNT
    );

endinterface

// File: rtl/sized_fifo_cnt_wrap_ctr.sv
// Modulo-depth pointer: wraps to 0 after depth-1 by explicit compare, so depth need not be 2^n.
module sized_fifo_cnt_wrap_ctr
    import sized_fifo_cnt_pkg::*;
#(
    parameter int unsigned depth = 4,
    localparam int unsigned PW   = ptr_w(depth)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PW'(depth - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sized_fifo_cnt.sv
// Parametrised-depth single-clock FIFO with registered COUNT and almost-full/almost-empty flags.
// Define FIFO_RESET_DATA_EN to zero the storage on reset and CLR.
module sized_fifo_cnt
    import sized_fifo_cnt_pkg::*;
#(
    parameter int unsigned width   = 1,
    parameter int unsigned depth   = 4,
    parameter int unsigned guarded = 1,
    parameter int unsigned af_lvl  = depth - 1,
    parameter int unsigned ae_lvl  = 1
) (
    input  logic           CLK,
    input  logic           RST,
    sized_fifo_cnt_if.slave bus
);

    localparam int unsigned CW       = cnt_w(depth);
    localparam int unsigned PW       = ptr_w(depth);
    localparam logic        GUARD    = (guarded != 0);
    localparam logic        AF_N_RST = (af_lvl != 0);

    logic [width-1:0] mem_q [depth];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic             full_n_q, full_n_d;
    logic             empty_n_q, empty_n_d;
    logic             af_n_q, af_n_d;
    logic             ae_n_q, ae_n_d;
    logic             full_c, empty_c, enq_ok_c, deq_ok_c;

    assign full_c  = (count_q == CW'(depth));
    assign empty_c = (count_q == '0);

    // Illegal halves are dropped; a guarded full ENQ+DEQ drops both.
    assign enq_ok_c = bus.ENQ && !bus.CLR && (!full_c || (bus.DEQ && !GUARD));
    assign deq_ok_c = bus.DEQ && !bus.CLR && !empty_c && !(full_c && bus.ENQ && GUARD);

    sized_fifo_cnt_wrap_ctr #(.depth(depth)) u_rd_ptr (
        .clk   (CLK),
        .rst_n (RST),
        .clr_i (bus.CLR),
        .inc_i (deq_ok_c),
        .ptr_o (rd_ptr)
    );

    sized_fifo_cnt_wrap_ctr #(.depth(depth)) u_wr_ptr (
        .clk   (CLK),
        .rst_n (RST),
        .clr_i (bus.CLR),
        .inc_i (enq_ok_c),
        .ptr_o (wr_ptr)
    );

    // Next occupancy and flags, all derived from the next count.
    always_comb begin
        count_d = count_q;
        if (bus.CLR) begin
            count_d = '0;
        end else if (enq_ok_c && !deq_ok_c) begin
            count_d = count_q + CW'(1);
        end else if (!enq_ok_c && deq_ok_c) begin
            count_d = count_q - CW'(1);
        end
        full_n_d  = (count_d != CW'(depth));
        empty_n_d = (count_d != '0);
        af_n_d    = !(32'(count_d) >= af_lvl);
        ae_n_d    = !(32'(count_d) <= ae_lvl);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q   <= '0;
            full_n_q  <= RST_FULL_N;
            empty_n_q <= RST_EMPTY_N;
            af_n_q    <= AF_N_RST;
            ae_n_q    <= RST_ALMOST_EMPTY_N;
        end else begin
            count_q   <= count_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
            af_n_q    <= af_n_d;
            ae_n_q    <= ae_n_d;
        end
    end

`ifdef FIFO_RESET_DATA_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(depth); i++) mem_q[i] <= '0;
        end else if (bus.CLR) begin
            for (int i = 0; i < int'(depth); i++) mem_q[i] <= '0;
        end else if (enq_ok_c) begin
            mem_q[wr_ptr] <= bus.D_IN;
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (enq_ok_c) mem_q[wr_ptr] <= bus.D_IN;
    end
`endif

    assign bus.D_OUT          = mem_q[rd_ptr];
    assign bus.COUNT          = count_q;
    assign bus.FULL_N         = full_n_q;
    assign bus.EMPTY_N        = empty_n_q;
    assign bus.ALMOST_FULL_N  = af_n_q;
    assign bus.ALMOST_EMPTY_N = ae_n_q;

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (RST && bus.DEQ && !bus.CLR && empty_c)
            $warning("Dequeuing from empty fifo");
        if (RST && bus.ENQ && !bus.CLR && full_c && !(bus.DEQ && !GUARD))
            $warning("Enqueuing to a full fifo");
    end
`endif

endmodule

// File: tb/tb_sized_fifo_cnt.sv
// Directed bench for sized_fifo_cnt: four instances covering depth 5, depth 3 (guarded 0/1) and depth 8 thresholds.
module tb_sized_fifo_cnt;
    import sized_fifo_cnt_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] enq_v, deq_v, clr_v;
    logic [7:0] din;
    logic [7:0] dout [4];
    logic [3:0] cnt  [4];
    logic [3:0] fn, en, afn, aen;
    int unsigned n_chk;
    int unsigned n_pass;

    sized_fifo_cnt_if #(.width(8), .depth(5)) if0 ();
    sized_fifo_cnt_if #(.width(8), .depth(3)) if1 ();
    sized_fifo_cnt_if #(.width(8), .depth(3)) if2 ();
    sized_fifo_cnt_if #(.width(8), .depth(8)) if3 ();

    sized_fifo_cnt #(.width(8), .depth(5), .guarded(1)) u0 (.CLK(clk), .RST(rst_n), .bus(if0));
    sized_fifo_cnt #(.width(8), .depth(3), .guarded(0)) u1 (.CLK(clk), .RST(rst_n), .bus(if1));
    sized_fifo_cnt #(.width(8), .depth(3), .guarded(1)) u2 (.CLK(clk), .RST(rst_n), .bus(if2));
    sized_fifo_cnt #(.width(8), .depth(8), .guarded(1), .af_lvl(6), .ae_lvl(2)) u3 (
        .CLK(clk), .RST(rst_n), .bus(if3));

    assign if0.D_IN = din; assign if0.ENQ = enq_v[0]; assign if0.DEQ = deq_v[0]; assign if0.CLR = clr_v[0];
    assign if1.D_IN = din; assign if1.ENQ = enq_v[1]; assign if1.DEQ = deq_v[1]; assign if1.CLR = clr_v[1];
    assign if2.D_IN = din; assign if2.ENQ = enq_v[2]; assign if2.DEQ = deq_v[2]; assign if2.CLR = clr_v[2];
    assign if3.D_IN = din; assign if3.ENQ = enq_v[3]; assign if3.DEQ = deq_v[3]; assign if3.CLR = clr_v[3];

    assign dout[0] = if0.D_OUT; assign cnt[0] = 4'(if0.COUNT);
    assign dout[1] = if1.D_OUT; assign cnt[1] = 4'(if1.COUNT);
    assign dout[2] = if2.D_OUT; assign cnt[2] = 4'(if2.COUNT);
    assign dout[3] = if3.D_OUT; assign cnt[3] = 4'(if3.COUNT);
    assign fn  = {if3.FULL_N, if2.FULL_N, if1.FULL_N, if0.FULL_N};
    assign en  = {if3.EMPTY_N, if2.EMPTY_N, if1.EMPTY_N, if0.EMPTY_N};
    assign afn = {if3.ALMOST_FULL_N, if2.ALMOST_FULL_N, if1.ALMOST_FULL_N, if0.ALMOST_FULL_N};
    assign aen = {if3.ALMOST_EMPTY_N, if2.ALMOST_EMPTY_N, if1.ALMOST_EMPTY_N, if0.ALMOST_EMPTY_N};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock of strobes on unit u; outputs are sampled 1 time unit after the edge.
    task automatic op(input int u, input logic e, input logic d, input logic c, input logic [7:0] v);
        enq_v[u[1:0]] = e;
        deq_v[u[1:0]] = d;
        clr_v[u[1:0]] = c;
        din = v;
        @(posedge clk);
        #1;
        enq_v = '0;
        deq_v = '0;
        clr_v = '0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        enq_v  = '0;
        deq_v  = '0;
        clr_v  = '0;
        din    = '0;
        #2;

        // Reset held with ENQ pulsing: nothing may change.
        enq_v[0] = 1'b1;
        din      = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",   32'(cnt[0]), 32'd0);
        chk("rst_empty_n", 32'(en[0]),  32'd0);
        chk("rst_full_n",  32'(fn[0]),  32'd1);
        chk("rst_ae_n",    32'(aen[0]), 32'd0);
        chk("rst_af_n",    32'(afn[0]), 32'd1);
        enq_v = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_count", 32'(cnt[0]), 32'd0);

        // depth 5: fill 1..5, reject extra ENQ, drain in order.
        for (int k = 1; k <= 5; k++) begin
            op(0, 1'b1, 1'b0, 1'b0, 8'(k));
            if (k == 1) begin
                chk("d5_first_head",    32'(dout[0]), 32'd1);
                chk("d5_first_empty_n", 32'(en[0]),   32'd1);
            end
        end
        chk("d5_full_count", 32'(cnt[0]), 32'd5);
        chk("d5_full_n",     32'(fn[0]),  32'd0);
        chk("d5_af_n",       32'(afn[0]), 32'd0);
        chk("d5_ae_n",       32'(aen[0]), 32'd1);
        op(0, 1'b1, 1'b0, 1'b0, 8'd99);
        chk("d5_enq_full_count", 32'(cnt[0]),  32'd5);
        chk("d5_enq_full_head",  32'(dout[0]), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            chk("d5_drain_data", 32'(dout[0]), 32'(k));
            op(0, 1'b0, 1'b1, 1'b0, 8'd0);
        end
        chk("d5_empty_n", 32'(en[0]),  32'd0);
        chk("d5_count0",  32'(cnt[0]), 32'd0);
        op(0, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("d5_deq_empty_count", 32'(cnt[0]), 32'd0);
        op(0, 1'b1, 1'b1, 1'b0, 8'h42);
        chk("d5_enqdeq_empty_count", 32'(cnt[0]),  32'd1);
        chk("d5_enqdeq_empty_head",  32'(dout[0]), 32'h42);

        // depth 3 wrap: 10 simultaneous ENQ+DEQ at count 2.
        op(1, 1'b1, 1'b0, 1'b0, 8'd10);
        op(1, 1'b1, 1'b0, 1'b0, 8'd11);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_head", 32'(dout[1]), 32'(10 + i));
            op(1, 1'b1, 1'b1, 1'b0, 8'(12 + i));
        end
        chk("wrap_count", 32'(cnt[1]), 32'd2);
        chk("wrap_head_end", 32'(dout[1]), 32'd20);

        // Full + ENQ + DEQ, unguarded: both happen.
        op(1, 1'b1, 1'b0, 1'b0, 8'd22);
        chk("ug_full_n", 32'(fn[1]), 32'd0);
        op(1, 1'b1, 1'b1, 1'b0, 8'd23);
        chk("ug_count", 32'(cnt[1]),  32'd3);
        chk("ug_head",  32'(dout[1]), 32'd21);
        for (int k = 21; k <= 23; k++) begin
            chk("ug_drain", 32'(dout[1]), 32'(k));
            op(1, 1'b0, 1'b1, 1'b0, 8'd0);
        end
        chk("ug_empty_n", 32'(en[1]), 32'd0);

        // Full + ENQ + DEQ, guarded: state unchanged.
        for (int k = 1; k <= 3; k++) op(2, 1'b1, 1'b0, 1'b0, 8'(k));
        op(2, 1'b1, 1'b1, 1'b0, 8'd4);
        chk("g_count",  32'(cnt[2]),  32'd3);
        chk("g_head",   32'(dout[2]), 32'd1);
        chk("g_full_n", 32'(fn[2]),   32'd0);
        for (int k = 1; k <= 3; k++) begin
            chk("g_drain", 32'(dout[2]), 32'(k));
            op(2, 1'b0, 1'b1, 1'b0, 8'd0);
        end
        chk("g_empty_n", 32'(en[2]), 32'd0);

        // CLR with concurrent ENQ at count 2.
        op(2, 1'b1, 1'b0, 1'b0, 8'd7);
        op(2, 1'b1, 1'b0, 1'b0, 8'd8);
        chk("clr_pre_count", 32'(cnt[2]), 32'd2);
        op(2, 1'b1, 1'b0, 1'b1, 8'd9);
        chk("clr_count",   32'(cnt[2]), 32'd0);
        chk("clr_empty_n", 32'(en[2]),  32'd0);
        chk("clr_full_n",  32'(fn[2]),  32'd1);
        chk("clr_ae_n",    32'(aen[2]), 32'd0);
`ifdef FIFO_RESET_DATA_EN
        chk("clr_dout_zero", 32'(dout[2]), 32'd0);
`endif
        op(2, 1'b1, 1'b0, 1'b0, 8'd5);
        chk("clr_after_count", 32'(cnt[2]),  32'd1);
        chk("clr_after_head",  32'(dout[2]), 32'd5);

        // Thresholds: depth 8, af_lvl 6, ae_lvl 2.
        chk("th_ae_n_0", 32'(aen[3]), 32'd0);
        chk("th_af_n_0", 32'(afn[3]), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            op(3, 1'b1, 1'b0, 1'b0, 8'(k));
            chk("th_af_n", 32'(afn[3]), 32'(k < 6));
            chk("th_ae_n", 32'(aen[3]), 32'(k > 2));
        end
        chk("th_count", 32'(cnt[3]), 32'd8);
        chk("th_full_n", 32'(fn[3]), 32'd0);
        op(3, 1'b0, 1'b1, 1'b0, 8'd0);
        op(3, 1'b0, 1'b1, 1'b0, 8'd0);
        op(3, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("th_af_n_rise", 32'(afn[3]), 32'd1);
        chk("th_head",      32'(dout[3]), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
